// File: rtl/fb_blit_scheduler.sv
// fb_blit_scheduler
//   Drives a single frame-buffer write port. During active video it writes the
//   clear colour at the beam position; once per frame, on the first cycle the
//   scan reaches VB_LINE, it latches four sprite descriptors and blits each
//   valid one, one pixel per cycle, in ascending slot order.
//
// Ports
//   clk, r                     clock, synchronous active-high reset
//   DrawX, DrawY               current scan position
//   spr_valid/x/y/color        four sprite slots (slot n in the lowest field n)
//   clear_color                background colour
//   we, addr, color            frame-buffer write port (combinational)
//   busy, frame_done, overrun  status: not idle, one-cycle end pulse, sticky abort
//
// Optional feature: define SPRITE_CLIP_EN to suppress writes of sprite pixels
// that fall outside the 640x480 visible area (timing is unchanged).
module fb_blit_scheduler #(
  parameter int unsigned SPR_W   = 10,
  parameter int unsigned SPR_H   = 10,
  parameter int unsigned X_SIZE  = 640,
  parameter int unsigned VB_LINE = 481
) (
  input  logic        clk,
  input  logic        r,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [3:0]  spr_valid,
  input  logic [39:0] spr_x,
  input  logic [39:0] spr_y,
  input  logic [31:0] spr_color,
  input  logic [7:0]  clear_color,
  output logic        we,
  output logic [18:0] addr,
  output logic [7:0]  color,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [1:0] {StIdle, StLatch, StBlit, StDone} state_e;

  localparam logic [5:0] DxLast = 6'(SPR_W - 1);
  localparam logic [5:0] DyLast = 6'(SPR_H - 1);
  localparam logic [9:0] VbLine = 10'(VB_LINE);

  state_e     state_q, state_d;
  logic [9:0] prev_y_q;
  logic [5:0] dx_q, dx_d, dy_q, dy_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0] valid_q, valid_d;
  logic [9:0] x_q [4];
  logic [9:0] x_d [4];
  logic [9:0] y_q [4];
  logic [9:0] y_d [4];
  logic [7:0] col_q [4];
  logic [7:0] col_d [4];
  logic       overrun_q, overrun_d;

  // Both events are edges of DrawY so a held value never retriggers.
  logic vb_edge, abort;
  assign vb_edge = (DrawY == VbLine) && (prev_y_q != VbLine);
  assign abort   = (DrawY == 10'd0) && (prev_y_q != 10'd0);

  // Lowest valid slot of the live inputs, used only on the LATCH cycle.
  logic [1:0] first_slot;
  always_comb begin
    first_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (spr_valid[i]) first_slot = 2'(i);
    end
  end

  // Next higher latched valid slot above the current one.
  logic [1:0] next_slot;
  logic       has_next;
  always_comb begin
    next_slot = slot_q;
    has_next  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (valid_q[i] && (i > int'(slot_q))) begin
        next_slot = 2'(i);
        has_next  = 1'b1;
      end
    end
  end

  // Current sprite pixel position; 11-bit sums keep the carry for clipping.
  logic [10:0] px, py;
  logic [31:0] blit_lin, idle_lin;
  assign px       = {1'b0, x_q[slot_q]} + {5'b0, dx_q};
  assign py       = {1'b0, y_q[slot_q]} + {5'b0, dy_q};
  assign blit_lin = 32'(px) + 32'(py) * X_SIZE;
  assign idle_lin = 32'(DrawX) + 32'(DrawY) * X_SIZE;

  always_comb begin
    we    = 1'b0;
    addr  = '0;
    color = '0;
    unique case (state_q)
      StIdle: begin
        if ((DrawY < 10'd480) && (DrawX < 10'd640)) begin
          we    = 1'b1;
          addr  = idle_lin[18:0];
          color = clear_color;
        end
      end
      StBlit: begin
        addr  = blit_lin[18:0];
        color = col_q[slot_q];
`ifdef SPRITE_CLIP_EN
        we    = !abort && (px < 11'd640) && (py < 11'd480);
`else
        we    = !abort;
`endif
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);
  assign overrun    = overrun_q;

  always_comb begin
    state_d   = state_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    slot_d    = slot_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    col_d     = col_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (vb_edge) state_d = StLatch;
      end
      StLatch: begin
        valid_d = spr_valid;
        for (int i = 0; i < 4; i++) begin
          x_d[i]   = spr_x[10*i +: 10];
          y_d[i]   = spr_y[10*i +: 10];
          col_d[i] = spr_color[8*i +: 8];
        end
        dx_d = '0;
        dy_d = '0;
        if (abort) begin
          overrun_d = 1'b1;
          state_d   = StDone;
        end else if (|spr_valid) begin
          slot_d  = first_slot;
          state_d = StBlit;
        end else begin
          state_d = StDone;
        end
      end
      StBlit: begin
        if (abort) begin
          overrun_d = 1'b1;
          state_d   = StDone;
        end else if (dx_q == DxLast) begin
          dx_d = '0;
          if (dy_q == DyLast) begin
            dy_d = '0;
            if (has_next) slot_d = next_slot;
            else          state_d = StDone;
          end else begin
            dy_d = dy_q + 6'd1;
          end
        end else begin
          dx_d = dx_q + 6'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q   <= StIdle;
      prev_y_q  <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      slot_q    <= '0;
      valid_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        col_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      prev_y_q  <= DrawY;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      slot_q    <= slot_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
    end
  end

endmodule

// File: doc/fb_blit_scheduler.md
FB_BLIT_SCHEDULER -- requirements
Module: fb_blit_scheduler

Interface
REQ-001 SHALL have parameter SPR_W, default 10, sprite width in pixels (1..64).
REQ-002 SHALL have parameter SPR_H, default 10, sprite height in pixels (1..64).
REQ-003 SHALL have parameter X_SIZE, default 640, frame-buffer line pitch in pixels.
REQ-004 SHALL have parameter VB_LINE, default 481, DrawY value that triggers sprite blitting.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port r  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports DrawX, DrawY  input  10 each  current VGA scan position.
REQ-008 SHALL have port spr_valid  input  4  per-slot enable, slot 0 in bit 0.
REQ-009 SHALL have ports spr_x, spr_y  input  40 each  four 10-bit sprite origins, slot n in bits [10n+9:10n].
REQ-010 SHALL have port spr_color  input  32  four 8-bit sprite colours, slot n in bits [8n+7:8n].
REQ-011 SHALL have port clear_color  input  8  background colour.
REQ-012 SHALL have ports we  output  1, addr  output  19, color  output  8  frame-buffer write port.
REQ-013 SHALL have ports busy  output  1 (high outside IDLE), frame_done  output  1 (one-cycle pulse), overrun  output  1 (sticky).

Function
REQ-014 SHALL implement states IDLE, LATCH, BLIT, DONE.
REQ-015 In IDLE with DrawY<480 and DrawX<640: we=1, addr=DrawX+DrawY*X_SIZE, color=clear_color; otherwise in IDLE we=0, addr=0, color=0.
REQ-016 IDLE->LATCH on the first cycle DrawY==VB_LINE, detected as a change from the previous cycle's DrawY; holding DrawY at VB_LINE SHALL NOT retrigger.
REQ-017 LATCH (one cycle, we=0) SHALL capture spr_valid, spr_x, spr_y and spr_color; later input changes SHALL NOT affect the current frame.
REQ-018 LATCH->BLIT at the lowest valid slot; LATCH->DONE if no slot is valid.
REQ-019 BLIT SHALL emit one pixel per cycle in row-major order: addr=(x+dx)+(y+dy)*X_SIZE truncated to 19 bits, color=slot colour, with dx in 0..SPR_W-1 and dy in 0..SPR_H-1.
REQ-020 After pixel (SPR_W-1, SPR_H-1), BLIT SHALL advance to the next higher valid slot on the next cycle with no gap, or to DONE after the last valid slot.
REQ-021 Each sprite SHALL occupy exactly SPR_W*SPR_H cycles, so four sprites take 400 cycles at defaults.
REQ-022 DONE SHALL last one cycle with frame_done=1 and we=0, then go to IDLE.
REQ-023 If DrawY changes to 0 while in LATCH or BLIT, SHALL set overrun=1, abort with no write that cycle, and go to DONE.
REQ-024 Slots SHALL write in ascending order; where sprites overlap, the higher slot's colour SHALL end in memory.
REQ-025 we, addr and color SHALL be combinational from the state, counter and latch registers plus DrawX/DrawY; they SHALL NOT depend on the live spr_* inputs.

Reset
REQ-026 r=1 at a rising edge SHALL force state IDLE, clear dx, dy, slot index, latches and the previous-DrawY register, and clear overrun.
REQ-027 After reset, busy=0 and frame_done=0; IDLE outputs follow REQ-015.
REQ-028 Reset asserted mid-BLIT SHALL take effect at that edge, with no further sprite writes and no frame_done.

Configuration
REQ-029 Macro SPRITE_CLIP_EN, when defined, SHALL force we=0 in BLIT for any pixel with x+dx>=640 or y+dy>=480, using 11-bit sums; timing and pixel count SHALL be unchanged.
REQ-030 Without SPRITE_CLIP_EN, every BLIT pixel SHALL be written at its truncated address.

Verification
REQ-031 Reset, then DrawX=5, DrawY=2 -> we=1, addr=1285, color=clear_color.
REQ-032 spr_valid=4'b0001, slot0 at (100,50), colour 8'h03, DrawY steps 480->481 -> LATCH, then 100 writes from addr 32100 to 37869, then frame_done for one cycle.
REQ-033 spr_valid=4'b1010 -> slot 1 writes 100 pixels, slot 3 writes 100 pixels back-to-back, 201 cycles from BLIT entry to the frame_done pulse.
REQ-034 spr_valid=0 -> LATCH, DONE, frame_done after 2 cycles, no writes.
REQ-035 SPRITE_CLIP_EN defined, sprite at (635,475) -> 25 writes, 75 suppressed, BLIT still 100 cycles.
REQ-036 DrawY set to 0 at pixel 40 of a sprite -> overrun=1 and remains 1; r=1 -> overrun=0, state IDLE.
